// File: rtl/spi_slave_if.sv
// SPI pin bundle plus tx/rx word handshake between spi_slave and its host logic.
interface spi_slave_if #(parameter int DATA_WIDTH = 8);
    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  busy;

    modport slave (
        input  sclk, cs, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
    modport master (
        output sclk, cs, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampling sclk/cs/mosi in the clk domain.
// One-entry tx buffer feeds the shift register; DEFAULT_TX is sent when it is empty.
module spi_slave #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '0
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    state_t                state;
    logic [2:0]            sclk_q;
    logic [2:0]            cs_q;
    logic [1:0]            mosi_q;
    logic                  primed;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [CW-1:0]         bitcnt;
    logic                  buf_full;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  busy;

    logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                  load, tx_wr;
    logic [DATA_WIDTH-1:0] load_word;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];

    // A cs rise outranks any sclk edge seen in the same cycle.
    assign load = (state == IDLE && cs_fall) ||
                  (state == SHIFT && !cs_rise && sclk_fall && bitcnt == '0);
    assign load_word = buf_full ? buf_data : DEFAULT_TX;
    assign tx_wr     = bus.tx_valid & ~buf_full;

    assign bus.miso        = (state == SHIFT) & sr[DATA_WIDTH-1];
    assign bus.tx_ready    = ~buf_full;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.tx_underrun = tx_underrun;
    assign bus.busy        = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= '0;
            cs_q        <= '1;
            mosi_q      <= '0;
            primed      <= 1'b0;
            state       <= WAIT_IDLE;
            sr          <= '0;
            rx_sr       <= '0;
            bitcnt      <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], bus.sclk};
            cs_q        <= {cs_q[1:0], bus.cs};
            mosi_q      <= {mosi_q[0], bus.mosi};
            primed      <= 1'b1;
            busy        <= ~cs_q[1];
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            case (state)
                // cs_q holds reset values until a real pin sample has arrived;
                // primed keeps a mid-frame reset from mistaking them for idle.
                WAIT_IDLE: if (primed && cs_q[1] && cs_q[0]) state <= IDLE;
                IDLE: begin
                    bitcnt <= '0;
                    if (cs_fall) state <= SHIFT;
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state  <= IDLE;
                        bitcnt <= '0;
                    end else if (sclk_rise) begin
                        rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_q[1]};
                        if (bitcnt == CW'(DATA_WIDTH - 1)) begin
                            rx_data  <= {rx_sr[DATA_WIDTH-2:0], mosi_q[1]};
                            rx_valid <= 1'b1;
                            bitcnt   <= '0;
                        end else begin
                            bitcnt <= bitcnt + CW'(1);
                        end
                    end else if (sclk_fall && bitcnt != '0) begin
                        sr <= sr << 1;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
            if (load) begin
                sr <= load_word;
                if (buf_full) buf_full    <= 1'b0;
                else          tx_underrun <= 1'b1;
            end
            // Mutually exclusive with the buffer-emptying load above via buf_full.
            if (tx_wr) begin
                buf_data <= bus.tx_data;
                buf_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Drives spi_slave as a mode-0 master and checks it against a word-level model
// of the tx buffer, loads, underruns and received words.
module tb_spi_slave;
    localparam int         W   = 8;
    localparam logic [7:0] DEF = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_WIDTH(W)) bus();

    spi_slave #(.DATA_WIDTH(W), .DEFAULT_TX(DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: tx buffer occupancy, expected rx word, expected underruns.
    bit         m_full;
    logic [7:0] m_buf;
    logic [7:0] exp_rx;
    int         ue_cnt;
    logic [7:0] mw[4];

    int n_rxv = 0;
    int n_und = 0;
    always @(negedge clk) begin
        if (bus.rx_valid)    n_rxv++;
        if (bus.tx_underrun) n_und++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic do_load(output logic [7:0] w);
        if (m_full) begin
            w      = m_buf;
            m_full = 1'b0;
        end else begin
            w = DEF;
            ue_cnt++;
        end
    endtask

    task automatic wr(input logic [7:0] v);
        @(negedge clk);
        chk("tx_ready", bus.tx_ready, !m_full);
        bus.tx_valid = 1'b1;
        bus.tx_data  = v;
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = v;
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic frame(input int nw, input int stop_bits, input int rst_bits,
                         input bit mid_wr, input logic [7:0] mid_val);
        logic [7:0] got, expw;
        int         rx0, ue0, nbits, exp_n;
        bit         cut, dead;
        rx0 = n_rxv; ue0 = ue_cnt; nbits = 0; cut = 1'b0; dead = 1'b0;
        got = '0;
        bus.cs = 1'b0;
        do_load(expw);
        for (int w = 0; w < nw && !cut; w++) begin
            got = '0;
            for (int b = 0; b < W; b++) begin
                bus.mosi = mw[w][W-1-b];
                half();
                if (w == 0 && b == 0) chk("busy_hi", bus.busy, 1'b1);
                got[W-1-b] = bus.miso;
                if (dead) chk("miso_dead", bus.miso, 1'b0);
                bus.sclk = 1'b1;
                nbits++;
                if (nbits == rst_bits) begin
                    rst = 1'b1;
                    repeat (2) @(negedge clk);
                    chk("rst_miso", bus.miso, 1'b0);
                    chk("rst_ready", bus.tx_ready, 1'b1);
                    chk("rst_rx", bus.rx_data, 8'h00);
                    chk("rst_busy", bus.busy, 1'b0);
                    chk("rst_und", bus.tx_underrun, 1'b0);
                    rst = 1'b0; m_full = 1'b0; exp_rx = '0; dead = 1'b1;
                    repeat (3) @(negedge clk);
                end else if (mid_wr && w == 0 && b == 2) begin
                    wr(mid_val);
                    repeat (3) @(negedge clk);
                end else begin
                    half();
                end
                if (nbits == stop_bits) begin
                    cut = 1'b1;
                    break;
                end
                if (b == W-1 && !dead) chk("miso_word", got, expw);
                if (b == W-1 && w == nw-1) break;
                bus.sclk = 1'b0;
                if (b == W-1 && !dead) do_load(expw);
            end
        end
        bus.cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("miso_idle", bus.miso, 1'b0);
        @(negedge clk);
        chk("busy_lo", bus.busy, 1'b0);
        bus.sclk = 1'b0;
        half();
        exp_n = (stop_bits > 0 || rst_bits > 0) ? 0 : nw;
        if (exp_n > 0) exp_rx = mw[nw-1];
        chk("rx_cnt", n_rxv - rx0, exp_n);
        chk("und_cnt", n_und - ue0, ue_cnt - ue0);
        chk("rx_data", bus.rx_data, exp_rx);
        chk("ready_end", bus.tx_ready, !m_full);
    endtask

    initial begin
        bus.sclk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = '0;
        m_full = 1'b0; m_buf = '0; exp_rx = '0; ue_cnt = 0;
        for (int i = 0; i < 4; i++) mw[i] = '0;

        repeat (3) @(negedge clk);
        chk("init_miso", bus.miso, 1'b0);
        chk("init_ready", bus.tx_ready, 1'b1);
        chk("init_rx", bus.rx_data, 8'h00);
        chk("init_rxv", bus.rx_valid, 1'b0);
        chk("init_und", bus.tx_underrun, 1'b0);
        chk("init_busy", bus.busy, 1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        wr(8'hA5); mw[0] = 8'h3C;
        frame(1, 0, 0, 1'b0, 8'h00);

        mw[0] = 8'($urandom);
        frame(1, 0, 0, 1'b0, 8'h00);

        wr(8'h81); mw[0] = 8'($urandom); mw[1] = 8'($urandom);
        frame(2, 0, 0, 1'b1, 8'h7E);

        mw[0] = 8'($urandom);
        frame(1, 5, 0, 1'b0, 8'h00);
        mw[0] = 8'($urandom);
        frame(1, 0, 0, 1'b0, 8'h00);

        wr(8'h5A); mw[0] = 8'($urandom);
        frame(1, 0, 3, 1'b0, 8'h00);
        mw[0] = 8'($urandom);
        frame(1, 0, 0, 1'b0, 8'h00);

        wr(8'hC3);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h3E;
        repeat (4) begin
            @(negedge clk);
            chk("ready_full", bus.tx_ready, 1'b0);
        end
        bus.tx_valid = 1'b0;
        mw[0] = 8'($urandom);
        frame(1, 0, 0, 1'b1, 8'h3E);
        mw[0] = 8'($urandom);
        frame(1, 0, 0, 1'b0, 8'h00);

        for (int i = 0; i < 8; i++) begin
            int nw;
            nw = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) mw[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) wr(8'($urandom));
            frame(nw, 0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
